// File: rtl/regfile_dump_reader.sv
// Register-file dump initiator: walks FIRST_REG..LAST_REG two reads per cycle,
// tags each word with its register index and streams it out through a small FIFO.
module regfile_dump_reader #(
  parameter int FIRST_REG  = 0,
  parameter int LAST_REG   = 31,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_index,
  output logic [31:0] out_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 37;
  localparam logic [5:0]    FIRST_P = 6'(FIRST_REG);
  localparam logic [5:0]    LAST_P  = 6'(LAST_REG);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    ptr_q, ptr_d;
  logic [4:0]    rr1_q, rr1_d;
  logic [4:0]    rr2_q, rr2_d;
  logic          done_q, done_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];

  logic                  fifo_empty;
  logic                  pop;
  logic                  last_pair;
  logic                  last_single;
  logic                  push_en;
  logic                  push2;
  logic [1:0]            push_cnt;
  logic [CW-1:0]         free_slots;
  logic [CW-1:0]         need_slots;
  logic [AW-1:0]         wr_ptr_p1;
  logic [5:0]            ptr_p1, ptr_p2, ptr_p3;
  logic [EW-1:0]         word1, word2, head;
  logic [FIFO_DEPTH-1:0] wen1, wen2;

  // Six-bit pointer math keeps ptr+1 = 32 from wrapping before the clamp.
  function automatic logic [4:0] clamp_addr(input logic [5:0] a);
    return (a > LAST_P) ? LAST_P[4:0] : a[4:0];
  endfunction

  assign ptr_p1 = ptr_q + 6'd1;
  assign ptr_p2 = ptr_q + 6'd2;
  assign ptr_p3 = ptr_q + 6'd3;

  assign fifo_empty  = (count_q == '0);
  assign pop         = !fifo_empty && out_ready;
  assign last_single = (ptr_q == LAST_P);
  assign last_pair   = (ptr_p1 >= LAST_P);

  // A slot freed by this cycle's pop is usable by this cycle's push.
  assign need_slots = last_single ? CW'(1) : CW'(2);
  assign free_slots = DEPTH_C - count_q + CW'(pop);
  assign push_en    = (state_q == S_ISSUE) && (free_slots >= need_slots);
  assign push2      = push_en && !last_single;
  assign push_cnt   = {push2, push_en && !push2};

  assign wr_ptr_p1 = wr_ptr_q + AW'(1);
  assign word1     = {ptr_q[4:0], ReadData1};
  assign word2     = {ptr_p1[4:0], ReadData2};

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wen
      assign wen1[gi] = push_en && (wr_ptr_q == AW'(gi));
      assign wen2[gi] = push2 && (wr_ptr_p1 == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (wen1[i]) begin
        mem_q[i] <= word1;
      end else if (wen2[i]) begin
        mem_q[i] <= word2;
      end
    end
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_cnt);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push_cnt) - CW'(pop);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rr1_d   = rr1_q;
    rr2_d   = rr2_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          rr1_d   = clamp_addr(ptr_q);
          rr2_d   = clamp_addr(ptr_p1);
        end
      end
      S_ISSUE: begin
        // Without room the addresses are held and the same pair is re-read.
        if (push_en) begin
          if (last_pair) begin
            state_d = S_DRAIN;
          end else begin
            ptr_d = ptr_p2;
            rr1_d = clamp_addr(ptr_p2);
            rr2_d = clamp_addr(ptr_p3);
          end
        end
      end
      S_DRAIN: begin
        if (pop && (count_q == CW'(1))) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          ptr_d   = FIRST_P;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= FIRST_P;
      rr1_q    <= '0;
      rr2_q    <= '0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rr1_q    <= rr1_d;
      rr2_q    <= rr2_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign ReadRegister1 = rr1_q;
  assign ReadRegister2 = rr2_q;
  assign out_valid     = !fifo_empty;
  assign out_index     = fifo_empty ? '0 : head[36:32];
  assign out_data      = fifo_empty ? '0 : head[31:0];

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a full-range and a narrow odd-count instance share a
// behavioural register file; accepted words are scored against an index-ordered queue.
module tb_regfile_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_drv;
  logic        sel;
  logic        rdy;
  logic [31:0] regs [32];

  logic        start_a, busy_a, done_a, valid_a;
  logic [4:0]  rr1_a, rr2_a, idx_a;
  logic [31:0] rd1_a, rd2_a, data_a;
  logic        start_b, busy_b, done_b, valid_b;
  logic [4:0]  rr1_b, rr2_b, idx_b;
  logic [31:0] rd1_b, rd2_b, data_b;

  assign start_a = start_drv && !sel;
  assign start_b = start_drv && sel;

  regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .ReadRegister1(rr1_a), .ReadRegister2(rr2_a), .ReadData1(rd1_a), .ReadData2(rd2_a),
    .out_valid(valid_a), .out_ready(rdy), .out_index(idx_a), .out_data(data_a)
  );

  regfile_dump_reader #(.FIRST_REG(3), .LAST_REG(7), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .ReadRegister1(rr1_b), .ReadRegister2(rr2_b), .ReadData1(rd1_b), .ReadData2(rd2_b),
    .out_valid(valid_b), .out_ready(rdy), .out_index(idx_b), .out_data(data_b)
  );

  // Register file presents read data on the falling edge for the addresses of that cycle.
  always @(negedge clk) begin
    rd1_a <= regs[rr1_a];
    rd2_a <= regs[rr2_a];
    rd1_b <= regs[rr1_b];
    rd2_b <= regs[rr2_b];
  end

  logic        m_busy, m_done, m_valid;
  logic [4:0]  m_idx, m_rr1, m_rr2;
  logic [31:0] m_data;
  always_comb begin
    m_busy  = sel ? busy_b  : busy_a;
    m_done  = sel ? done_b  : done_a;
    m_valid = sel ? valid_b : valid_a;
    m_idx   = sel ? idx_b   : idx_a;
    m_data  = sel ? data_b  : data_a;
    m_rr1   = sel ? rr1_b   : rr1_a;
    m_rr2   = sel ? rr2_b   : rr2_a;
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } word_t;
  word_t exp_q[$];

  typedef struct {
    int vsel;
    int mode;
    int poke;
    int exp_words;
    int pattern;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic load_regs(input int pattern);
    for (int i = 0; i < 32; i++) begin
      regs[i] = (pattern == 0) ? 32'(i * 32'h11) : $urandom;
    end
  endtask

  // mode: 0 ready always, 1 toggling, 2 random, 3 twenty-cycle stall after six words
  task automatic run_dump(input int vid, input int vsel, input int mode, input int poke,
                          input int exp_words);
    int first, last, got, dones, cyc, stall_left;
    bit done_next, hold_valid, finished, stall_used;
    logic [36:0] held;
    logic [4:0]  addr_mid;
    word_t       w;
    first = (vsel != 0) ? 3 : 0;
    last  = (vsel != 0) ? 7 : 31;
    got = 0; dones = 0; cyc = 0; stall_left = 0;
    done_next = 0; hold_valid = 0; finished = 0; stall_used = 0;
    held = '0; addr_mid = '0;
    exp_q.delete();
    for (int i = first; i <= last; i++) exp_q.push_back('{5'(i), regs[i]});
    sel = (vsel != 0);
    rdy = 1'b1;
    start_drv = 1'b1;
    @(posedge clk);
    #1 start_drv = 1'b0;
    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      check("done", m_done, done_next);
      if (m_done) dones++;
      if (done_next) begin
        check("busy_at_done", m_busy, 0);
        check("valid_at_done", m_valid, 0);
        finished = 1;
      end else begin
        check("busy", m_busy, 1);
        if (hold_valid) check("head_stable", {m_valid, m_idx, m_data}, {1'b1, held});
        if (mode == 0 && got > 0) check("no_bubble", m_valid, 1);
        if (mode == 3 && stall_left == 10) addr_mid = m_rr1;
        if (mode == 3 && stall_left == 1) begin
          check("stall_addr_held", m_rr1, addr_mid);
          check("stall_valid", m_valid, 1);
        end
        hold_valid = m_valid && !rdy;
        held = {m_idx, m_data};
        if (m_valid && rdy) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra_word: got index %0d required none", m_idx);
          end else begin
            w = exp_q.pop_front();
            check("index", m_idx, w.idx);
            check("data", m_data, w.data);
            got++;
            if (exp_q.size() == 0) begin
              done_next = 1;
              if (poke != 0) start_drv = 1'b1;
            end
          end
        end
        if (poke != 0 && cyc == 5) start_drv = 1'b1;
        @(posedge clk);
        #1 start_drv = 1'b0;
        case (mode)
          1: rdy = ~rdy;
          2: rdy = (($urandom % 4) != 0);
          3: begin
            if (stall_left > 0) begin
              stall_left--;
              rdy = (stall_left == 0);
            end else if (!stall_used && got >= 6) begin
              stall_used = 1;
              stall_left = 20;
              rdy = 1'b0;
            end else begin
              rdy = 1'b1;
            end
          end
          default: rdy = 1'b1;
        endcase
      end
    end
    if (!finished) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: dump %0d got %0d words, required done within 400 cycles", vid, got);
    end
    check("word_count", 64'(got), 64'(exp_words));
    check("done_count", 64'(dones), 1);
    check("last_addr1", m_rr1, (vsel != 0) ? 5'd7 : 5'd30);
    check("last_addr2", m_rr2, (vsel != 0) ? 5'd7 : 5'd31);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("idle_done", m_done, 0);
      check("idle_busy", m_busy, 0);
      check("idle_valid", m_valid, 0);
    end
    $display("dump %0d: sel=%0d mode=%0d poke=%0d words=%0d dones=%0d", vid, vsel, mode,
             poke, got, dones);
  endtask

  initial begin
    int got, cyc;
    vecs[0] = '{0, 0, 0, 32, 0};
    vecs[1] = '{1, 0, 0, 5, 1};
    vecs[2] = '{0, 3, 0, 32, 1};
    vecs[3] = '{0, 1, 0, 32, 1};
    vecs[4] = '{1, 1, 0, 5, 1};
    vecs[5] = '{0, 2, 0, 32, 1};
    vecs[6] = '{0, 0, 1, 32, 1};
    vecs[7] = '{1, 2, 1, 5, 1};

    rst_n = 1'b0;
    start_drv = 1'b0;
    sel = 1'b0;
    rdy = 1'b0;
    load_regs(0);
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_index", idx_a, 0);
    check("rst_data", data_a, 0);
    check("rst_addr1", rr1_a, 0);
    check("rst_addr2", rr2_a, 0);
    check("rst_busy_b", busy_b, 0);
    check("rst_valid_b", valid_b, 0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      load_regs(vecs[v].pattern);
      run_dump(v, vecs[v].vsel, vecs[v].mode, vecs[v].poke, vecs[v].exp_words);
    end

    // Asynchronous reset after ten accepted words aborts the dump with no done.
    load_regs(1);
    sel = 1'b0;
    rdy = 1'b1;
    got = 0;
    cyc = 0;
    start_drv = 1'b1;
    @(posedge clk);
    #1 start_drv = 1'b0;
    while (got < 10 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (valid_a && rdy) begin
        check("abort_index", idx_a, 5'(got));
        check("abort_data", data_a, regs[got]);
        got++;
      end
      @(posedge clk);
      #1;
    end
    check("abort_words", 64'(got), 10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy_a, 0);
    check("abort_valid", valid_a, 0);
    check("abort_index0", idx_a, 0);
    check("abort_data0", data_a, 0);
    check("abort_addr1", rr1_a, 0);
    check("abort_addr2", rr2_a, 0);
    check("abort_done", done_a, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_abort_done", done_a, 0);
      check("post_abort_busy", busy_a, 0);
    end
    $display("abort: words before reset=%0d", got);
    load_regs(1);
    run_dump(8, 0, 2, 0, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
